// File: rtl/dcache_arb_pkg.sv
// Shared types for the D-cache port arbiter: owner encoding, the latched
// request record, and the fixed walker request shape.
package dcache_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_WALK = 2'd2
    } owner_e;

    localparam logic [1:0] WLEN_DWORD = 2'd3;

    typedef struct packed {
        logic [63:0] addr;
        logic        wrn;
        logic [63:0] wdata;
        logic [1:0]  wlen;
    } dc_req_t;

    // Page-table walker only ever issues full-doubleword reads.
    function automatic dc_req_t walk_req(input logic [63:0] addr);
        dc_req_t r;
        r.addr  = addr;
        r.wrn   = 1'b0;
        r.wdata = '0;
        r.wlen  = WLEN_DWORD;
        return r;
    endfunction

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating streak counter; counts walker wins while the core waits so the
// arbiter can force a core grant once the limit is reached.
module arb_streak_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic             at_limit,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < limit)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single D-cache request port between the core LSU and the MMU
// walker; grants are latched and held on the port until the cache completes.
module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        virtual_mode_in,

    input  logic        core_req_valid,
    input  logic [63:0] core_req_addr,
    input  logic        core_req_write,
    input  logic [63:0] core_req_wdata,
    input  logic [1:0]  core_req_wlen,
    output logic        core_req_ready,
    output logic [63:0] core_resp_rdata,
    output logic        core_resp_valid,
    output logic        core_resp_write_done,

    input  logic        walk_req_valid,
    input  logic [63:0] walk_req_addr,
    output logic        walk_req_ready,
    output logic [63:0] walk_resp_data,
    output logic        walk_resp_valid,

    output logic        dc_en,
    output logic [63:0] dc_addr,
    output logic        dc_wrn,
    output logic [63:0] dc_wdata,
    output logic [1:0]  dc_wlen,
    output logic        dc_virtual_mode,
    input  logic [63:0] dc_rdata,
    input  logic        dc_valid,
    input  logic        dc_write_done,

    output logic [1:0]  owner
);

    localparam int STREAK_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CORE = 2'd1;
    localparam logic [1:0] ST_WALK = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    dc_req_t             hold;
    logic                busy;
    logic                in_idle;
    logic                core_win;
    logic                walk_win;
    logic                at_limit;
    logic                streak_inc;
    logic                streak_clr;
    logic [STREAK_W-1:0] streak_count;
    logic                rd_done;
    logic                wr_done;
    logic                core_rd_done;
    logic                core_wr_done;
    logic                walk_done;

    // Grants are blocked while reset is high so every output reads 0 in reset.
    assign in_idle  = (state == ST_IDLE) && !reset;
    assign core_win = in_idle && core_req_valid && (!walk_req_valid || at_limit);
    assign walk_win = in_idle && walk_req_valid && !core_win;

    assign core_req_ready = core_win;
    assign walk_req_ready = walk_win;

    // A read finishes only on dc_valid, a write only on dc_write_done.
    assign rd_done      = dc_valid && !hold.wrn;
    assign wr_done      = dc_write_done && hold.wrn;
    assign core_rd_done = (state == ST_CORE) && rd_done;
    assign core_wr_done = (state == ST_CORE) && wr_done;
    assign walk_done    = (state == ST_WALK) && rd_done;

    // NOTE: every combinationally assigned variable gets a default first so
    // no path leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (core_win) begin
                    state_nxt = ST_CORE;
                end else if (walk_win) begin
                    state_nxt = ST_WALK;
                end
            end
            ST_CORE: if (core_rd_done || core_wr_done) state_nxt = ST_IDLE;
            ST_WALK: if (walk_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the hold register is reset even though outputs are gated by
    // state, so no stale request survives a reset into a later transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold <= '0;
        end else if (core_win) begin
            hold <= '{addr:  core_req_addr,
                      wrn:   core_req_write,
                      wdata: core_req_wdata,
                      wlen:  core_req_wlen};
        end else if (walk_win) begin
            hold <= walk_req(walk_req_addr);
        end
    end

    assign streak_inc = walk_win && core_req_valid;
    assign streak_clr = core_win || ((state == ST_IDLE) && !core_req_valid);

    arb_streak_counter #(
        .WIDTH (STREAK_W)
    ) u_streak (
        .clk      (clk),
        .reset    (reset),
        .inc      (streak_inc),
        .clr      (streak_clr),
        .limit    (STREAK_W'(STARVE_LIMIT)),
        .at_limit (at_limit),
        .count    (streak_count)
    );

    // dc_en comes straight from the state flop, so it drops with async reset.
    assign busy            = (state != ST_IDLE);
    assign dc_en           = busy;
    assign dc_addr         = busy ? hold.addr  : '0;
    assign dc_wrn          = busy ? hold.wrn   : 1'b0;
    assign dc_wdata        = busy ? hold.wdata : '0;
    assign dc_wlen         = busy ? hold.wlen  : '0;
    assign dc_virtual_mode = virtual_mode_in && (state == ST_CORE);

    assign core_resp_valid      = core_rd_done;
    assign core_resp_rdata      = core_rd_done ? dc_rdata : '0;
    assign core_resp_write_done = core_wr_done;
    assign walk_resp_valid      = walk_done;
    assign walk_resp_data       = walk_done ? dc_rdata : '0;

    always_comb begin
        unique case (state)
            ST_CORE: owner = OWN_CORE;
            ST_WALK: owner = OWN_WALK;
            default: owner = OWN_NONE;
        endcase
    end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Sequential arbiter that shares the single D-cache request port between the core's load/store unit and the MMU page-table walker. It replaces the combinational `use_dcache` mux in the memory system. Each granted request is latched, held stable on the D-cache port until completion, and the response is routed back to its owner. The walker normally has priority; a streak counter guarantees the core is not starved.

## Interface
- `STARVE_LIMIT`, 4: consecutive walker grants allowed while a core request is pending before the core is forced ahead (range 1–15).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `virtual_mode_in` in 1: virtual-mode enable decoded from SATP.
- `core_req_valid` in 1: core request pending; held until accepted.
- `core_req_addr` in 64: core address.
- `core_req_write` in 1: 1 = write, 0 = read.
- `core_req_wdata` in 64: write data.
- `core_req_wlen` in 2: log2(bytes); 3 = 64-bit.
- `core_req_ready` out 1: core request accepted this cycle.
- `core_resp_rdata` out 64: read data.
- `core_resp_valid` out 1: one-cycle read-complete pulse.
- `core_resp_write_done` out 1: one-cycle write-complete pulse.
- `walk_req_valid` in 1: walker PTE read pending.
- `walk_req_addr` in 64: physical PTE address.
- `walk_req_ready` out 1: walker request accepted.
- `walk_resp_data` out 64: PTE data.
- `walk_resp_valid` out 1: one-cycle PTE-complete pulse.
- `dc_en` out 1: drives D-cache enable.
- `dc_addr` out 64: drives D-cache address.
- `dc_wrn` out 1: drives D-cache write/read select.
- `dc_wdata` out 64: drives D-cache write data.
- `dc_wlen` out 2: drives D-cache write length.
- `dc_virtual_mode` out 1: D-cache virtual-mode enable.
- `dc_rdata` in 64: D-cache read data.
- `dc_valid` in 1: D-cache read complete.
- `dc_write_done` in 1: D-cache write complete.
- `owner` out 2: current owner (NONE/CORE/WALK), for debug.

## Operation
- FSM states: IDLE, CORE, WALK.
- **IDLE:** arbitrate among pending requests.
  - Walker wins by default.
  - Core wins if it is the only requester, or if both are pending and `streak == STARVE_LIMIT`.
  - Winner's `*_req_ready` is asserted combinationally in the same cycle.
  - Request fields are latched into hold registers; the FSM moves to CORE or WALK.
- **Walker requests:** latched as a read with `dc_wrn=0`, `dc_wdata=0`, `dc_wlen=3`.
- **CORE/WALK:**
  - `dc_en=1` and `dc_*` come from the hold registers, stable for the whole transaction.
  - `dc_virtual_mode = virtual_mode_in && owner==CORE`; it is 0 in WALK and in IDLE.
- **Completion:**
  - A read completes on `dc_valid`; a write completes on `dc_write_done`.
  - A `dc_valid` seen during a write transaction is ignored.
  - On completion, pulse the owner's response signals for that cycle only: `*_rdata = dc_rdata`, else 0. Then return to IDLE.
- **Stray responses:** `dc_valid` or `dc_write_done` while in IDLE is ignored; no response pulse is generated.
- **Streak counter (4-bit):**
  - Increments on a walker grant while `core_req_valid` is high.
  - Clears on any core grant, or in IDLE when `core_req_valid` is low.
  - Saturates at `STARVE_LIMIT`.
- **Reset:** `reset` asserted at any time returns the FSM to IDLE, clears the counter, and zeroes all outputs.
  - An in-flight transaction is abandoned and no response pulse is emitted.
  - `dc_en` drops asynchronously.

## Timing
- Request accepted at cycle T (ready and valid both high); `dc_en` is high from T+1.
- Response is combinational from `dc_valid`/`dc_write_done` in cycle C (same-cycle routing). The FSM is in IDLE at C+1.
- Next grant is possible at C+1, with `dc_en` high at C+2. This gives one idle `dc_en=0` cycle between transactions, which the D-cache requires to observe a new request.
- Minimum transaction occupancy is 2 cycles (accept cycle plus one cycle for a D-cache hit).
- A requester must hold `valid` and its fields stable until ready. Ready is never asserted outside IDLE.
- If both requests arrive in the same cycle, exactly one ready is asserted.
- Reset values: FSM = IDLE, `owner = NONE`, and every output = 0.

## Structure
- Package `dcache_arb_pkg`:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_WALK} owner_e`.
  - `localparam WLEN_DWORD = 2'd3`.
  - A `dc_req_t` struct {addr, wrn, wdata, wlen} used for the hold register.
- One sub-module, `arb_streak_counter`: a saturating counter with `inc`/`clr`/`limit` ports and a `at_limit` output.

## Test plan
- **Core-only read:** core reads 0x8000_1000 with `dc_valid` after 3 cycles returning 0xDEAD_BEEF → `core_resp_valid` pulses 1 cycle with that data; `walk_resp_valid` stays 0; `dc_virtual_mode` follows `virtual_mode_in`.
- **Simultaneous requests:** core write of 0x55 (wlen 0) to 0x100 and walker read of 0x2000 in the same cycle → walker granted first with `dc_virtual_mode=0`; the core write is issued after one idle cycle; `core_resp_write_done` pulses.
- **Starvation guard:** continuous walker requests plus a pending core request, `STARVE_LIMIT=4` → exactly 4 walker grants, then the core is granted; the streak counter reads 0 afterwards.
- **Write ignores dc_valid:** `dc_valid` asserted during a core write → no response; completion occurs only on `dc_write_done`.
- **Reset mid-transaction:** reset asserted in WALK with `dc_en=1` → `dc_en=0` immediately, no `walk_resp_valid`, and IDLE after release. A late `dc_valid` is ignored.
- **Stray response in IDLE:** `dc_valid=1` while IDLE → no response pulse on either port.
